// File: rtl/mem_multicycle.sv
// Byte-addressable big-endian data memory with a fixed multi-cycle access and stall/done handshake.
// Latency LATENCY cycles accept->completion; enable during stall is dropped, not queued.
module mem_multicycle #(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 16,
   parameter int DEPTH   = 64,
   parameter int LATENCY = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              wr,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              stall,
   output logic              done,
   output logic              err
);

   localparam int BYTES = DATA_W / 8;
   localparam int OFF_W = $clog2(DEPTH);
   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              wr_q, wr_d;
   logic [OFF_W-1:0]  addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;
   logic              accept;
   logic              mem_we;
   logic              misalign;
   logic [DATA_W-1:0] rd_word;
   logic [7:0]        mem_q [0:DEPTH-1];

   // Upper address bits alias onto the array; they are deliberately dropped.
   logic unused_addr;
   assign unused_addr = ^addr;

   assign misalign = (addr[OFF_W-1:0] & OFF_W'(BYTES - 1)) != '0;

   always_comb begin
      rd_word = '0;
      for (int i = 0; i < BYTES; i++) begin
         rd_word[DATA_W-1-8*i -: 8] = mem_q[addr_q + OFF_W'(i)];
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      wr_d     = wr_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      err_d    = err_q;
      rdata_d  = rdata_q;
      accept   = 1'b0;
      mem_we   = 1'b0;
      stall    = 1'b0;
      done     = 1'b0;
      case (state_q)
         S_IDLE: accept = enable;
         S_BUSY: begin
            stall = 1'b1;
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               state_d = S_DONE;
               mem_we  = wr_q & ~err_q;
               rdata_d = (!wr_q && !err_q) ? rd_word : '0;
            end
         end
         S_DONE: begin
            done   = 1'b1;
            accept = enable;
            if (!enable) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (accept) begin
         state_d = S_BUSY;
         cnt_d   = CNT_W'(LATENCY - 1);
         wr_d    = wr;
         addr_d  = addr[OFF_W-1:0];
         wdata_d = data_in;
         err_d   = misalign;
      end
   end

   assign data_out = done ? rdata_q : '0;
   assign err      = done & err_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Array has no reset; an aborted write never reaches here since mem_we needs BUSY.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < BYTES; i++) begin
            mem_q[addr_q + OFF_W'(i)] <= wdata_q[DATA_W-1-8*i -: 8];
         end
      end
   end

endmodule

// File: tb/tb_mem_multicycle.sv
// Scoreboard bench for mem_multicycle (16-bit words, 64 bytes, latency 3).
module tb_mem_multicycle;

   logic        clk;
   logic        rst;
   logic        enable;
   logic        wr;
   logic [15:0] addr;
   logic [15:0] data_in;
   logic [15:0] data_out;
   logic        stall;
   logic        done;
   logic        err;

   mem_multicycle #(.DATA_W(16), .ADDR_W(16), .DEPTH(64), .LATENCY(3)) dut (
      .clk(clk), .rst(rst), .enable(enable), .wr(wr), .addr(addr),
      .data_in(data_in), .data_out(data_out), .stall(stall), .done(done), .err(err)
   );

   typedef struct {
      logic [15:0] d;
      logic        e;
   } exp_t;

   exp_t     sb[$];
   int       rise_cyc[$];
   logic [7:0] mem_m [0:63];
   int       n_chk = 0;
   int       n_fail = 0;
   int       cyc = 0;
   int       stall_cnt = 0;
   logic     prev_stall = 0;
   logic     prev_done = 0;

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [15:0] model_word(input logic [15:0] a);
      logic [5:0] o;
      o = a[5:0];
      return {mem_m[o], mem_m[o + 6'd1]};
   endfunction

   function automatic exp_t expect_for(input logic w, input logic [15:0] a, input logic [15:0] d);
      exp_t x;
      logic [5:0] o;
      o = a[5:0];
      x.d = 16'h0;
      x.e = a[0];
      if (!a[0]) begin
         if (w) begin
            mem_m[o]        = d[15:8];
            mem_m[o + 6'd1] = d[7:0];
         end else begin
            x.d = model_word(a);
         end
      end
      return x;
   endfunction

   // Observer: every cycle checks pulse shape, idle output, and pops on done.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst) begin
            stall_cnt  = 0;
            prev_stall = 0;
            prev_done  = 0;
         end else begin
            if (stall && !prev_stall) rise_cyc.push_back(cyc);
            if (stall) stall_cnt++;
            chk("err_without_done", {31'b0, err & ~done}, 0);
            chk("done_pulse_width", {31'b0, done & prev_done}, 0);
            if (done) begin
               chk("stall_len", stall_cnt, 3);
               stall_cnt = 0;
               if (sb.size() == 0) begin
                  chk("unexpected_done", 1, 0);
               end else begin
                  e = sb.pop_front();
                  chk("data_out", data_out, e.d);
                  chk("err", err, e.e);
               end
            end else begin
               chk("data_out_idle", data_out, 0);
            end
            prev_stall = stall;
            prev_done  = done;
         end
      end
   end

   task automatic wait_idle();
      int g = 0;
      @(negedge clk);
      while (stall && g < 20) begin
         @(negedge clk);
         g++;
      end
      if (g >= 20) chk("wait_idle_timeout", 1, 0);
   endtask

   task automatic issue(input logic w, input logic [15:0] a, input logic [15:0] d);
      wait_idle();
      enable  = 1'b1;
      wr      = w;
      addr    = a;
      data_in = d;
      sb.push_back(expect_for(w, a, d));
      @(posedge clk);
      #1 enable = 1'b0;
   endtask

   task automatic drain();
      int g = 0;
      while ((sb.size() != 0 || stall) && g < 40) begin
         @(negedge clk);
         #1;
         g++;
      end
      if (g >= 40) chk("drain_timeout", 1, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int base;
      logic [15:0] vals [4];
      rst = 1; enable = 0; wr = 0; addr = 0; data_in = 0;
      #3 rst = 0;
      #1;
      chk("reset_stall", stall, 0);
      chk("reset_done", done, 0);
      chk("reset_err", err, 0);
      chk("reset_data_out", data_out, 0);
      @(negedge clk); @(negedge clk);
      rst = 1;

      // Reset mid-write discards the write.
      issue(1, 16'h000A, 16'h1111);
      drain();
      wait_idle();
      enable = 1; wr = 1; addr = 16'h000A; data_in = 16'hBEEF;
      @(posedge clk);
      #1 enable = 0;
      @(negedge clk);
      chk("abort_busy_stall", stall, 1);
      #2 rst = 0;
      #1;
      chk("abort_stall", stall, 0);
      chk("abort_done", done, 0);
      chk("abort_data_out", data_out, 0);
      sb.delete();
      @(negedge clk); @(negedge clk);
      rst = 1;
      issue(0, 16'h000A, 16'h0);

      // Write/read and byte view.
      issue(1, 16'h0010, 16'h1234);
      issue(0, 16'h0010, 16'h0);
      drain();
      chk("byte_0x10", dut.mem_q[16], 8'h12);
      chk("byte_0x11", dut.mem_q[17], 8'h34);

      // Address wrap.
      issue(1, 16'h0050, 16'hABCD);
      issue(0, 16'h0010, 16'h0);

      // Misalignment.
      issue(1, 16'h0020, 16'h2020);
      issue(1, 16'h0022, 16'h2222);
      issue(1, 16'h0021, 16'h5555);
      issue(0, 16'h0021, 16'h0);
      issue(0, 16'h0020, 16'h0);
      issue(0, 16'h0022, 16'h0);
      drain();

      // Held enable with changing inputs during BUSY.
      @(negedge clk);
      enable = 1; wr = 0; addr = 16'h0020; data_in = 16'h0;
      sb.push_back(expect_for(0, 16'h0020, 16'h0));
      @(posedge clk);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         wr = 1;
         data_in = 16'hFFFF;
         addr = (i == 0) ? 16'h0010 : (i == 1) ? 16'h0022 : 16'h003E;
      end
      @(negedge clk);
      chk("hold_done_cycle", done, 1);
      wr = 0; addr = 16'h000A;
      sb.push_back(expect_for(0, 16'h000A, 16'h0));
      @(posedge clk);
      #1 enable = 0;
      drain();
      base = rise_cyc.size();
      chk("hold_period", rise_cyc[base-1] - rise_cyc[base-2], 4);

      // Back-to-back on the top word.
      vals[0] = 16'h0F0F; vals[1] = 16'hC3A5; vals[2] = 16'h7E81; vals[3] = 16'hFFFF;
      base = rise_cyc.size();
      for (int i = 0; i < 4; i++) begin
         issue(1, 16'h003E, vals[i]);
         issue(0, 16'h003E, 16'h0);
      end
      drain();
      chk("b2b_count", rise_cyc.size() - base, 8);
      for (int k = base + 1; k < rise_cyc.size(); k++) begin
         chk("b2b_period", rise_cyc[k] - rise_cyc[k-1], 4);
      end

      chk("scoreboard_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
